// File: rtl/context_operand_seq.sv
// Operand feeder for the combinational context stage. Buffers (A, B) pairs in
// a small circular FIFO, drops pairs whose B is zero, holds each surviving
// pair on A/B for HOLD cycles so XOUT can settle, then returns the captured
// XOUT over a valid/ready result stream.
module context_operand_seq #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBITS-1:0]         in_a,
  input  logic [NBITS-1:0]         in_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NBITS-1:0]         a,
  output logic [NBITS-1:0]         b,
  input  logic [NBITS-1:0]         xout,
  output logic [NBITS-1:0]         res,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     dz_err,
  output logic [7:0]               dz_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  // At least one bit so HOLD = 1 still yields a legal counter.
  localparam int unsigned HoldW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StHold, StEmit} state_e;

  state_e state_q, state_d;

  logic [NBITS-1:0] mem_a [DEPTH];
  logic [NBITS-1:0] mem_b [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [NBITS-1:0] a_q, b_q, res_q;
  logic             res_valid_q, dz_err_q;
  logic [7:0]       dz_cnt_q;

  logic push, pop, load, drop, capture, handshake;
  logic fifo_nonempty, head_zero;

  assign in_ready      = (count_q < CntW'(DEPTH));
  assign push          = in_valid & in_ready;
  assign fifo_nonempty = (count_q != '0);
  assign head_zero     = (mem_b[rd_ptr_q] == '0);

  assign a         = a_q;
  assign b         = b_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign dz_err    = dz_err_q;
  assign dz_cnt    = dz_cnt_q;
  assign count     = count_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: zero-divisor heads are dropped without leaving IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fifo_nonempty && !head_zero) state_d = StHold;
      StHold:  if (hold_cnt_q == '0) state_d = StEmit;
      StEmit:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: per-cycle control strobes for the FIFO and datapath
  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop  = 1'b1;
          drop = head_zero;
          load = !head_zero;
        end
      end
      StHold:  capture   = (hold_cnt_q == '0);
      StEmit:  handshake = res_ready;
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Datapath: operand hold, settle countdown, result capture, drop tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      hold_cnt_q  <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      dz_err_q    <= 1'b0;
      dz_cnt_q    <= '0;
    end else begin
      if (load) begin
        a_q        <= mem_a[rd_ptr_q];
        b_q        <= mem_b[rd_ptr_q];
        hold_cnt_q <= HoldInit;
      end else if (state_q == StHold && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HoldW'(1);
      end

      if (capture) begin
        res_q       <= xout;
        res_valid_q <= 1'b1;
      end else if (handshake) begin
        res_valid_q <= 1'b0;
      end

      dz_err_q <= drop;
      if (drop && dz_cnt_q != 8'hFF) dz_cnt_q <= dz_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_context_operand_seq.sv
// Bench for context_operand_seq: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a queue/timestamp reference model
// compared every cycle. The bench also plays the context stage, whose XOUT is
// deliberately wrong until A/B have been stable for a few cycles.
module tb_context_operand_seq;

  localparam int unsigned NBITS  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned HOLD   = 4;
  localparam int          Settle = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBITS-1:0] in_a = '0, in_b = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NBITS-1:0] a, b, xout, res;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             dz_err;
  logic [7:0]       dz_cnt;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  context_operand_seq #(.NBITS(NBITS), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .xout(xout), .res(res),
    .res_valid(res_valid), .res_ready(res_ready), .dz_err(dz_err),
    .dz_cnt(dz_cnt), .count(count)
  );

  // Context stage function (A*B + A - B, truncated to 8 bits).
  function automatic logic [7:0] ctx(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = x * y;
    return p[7:0] + x - y;
  endfunction

  // Context stage with settle behaviour: garbage until A/B stable long enough.
  int stab = 0;
  logic [7:0] a_seen = '0, b_seen = '0;
  assign xout = (stab >= Settle) ? ctx(a, b) : ~ctx(a, b);
  initial forever begin
    @(negedge clk);
    if (a !== a_seen || b !== b_seen) stab = 0;
    else if (stab < 1000) stab = stab + 1;
    a_seen = a;
    b_seen = b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp = n_cmp + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference model: pending pairs in a queue, job progress as timestamps.
  typedef struct packed {logic [7:0] pa; logic [7:0] pb;} pair_t;
  pair_t      mq[$];
  logic [7:0] m_a, m_b, m_res, m_dzcnt;
  bit         m_rv, m_busy, m_dzerr, m_live;
  int         mcyc, m_cap_at;

  initial forever begin
    pair_t p;
    bit    did_push;
    @(posedge clk);
    cyc  = cyc + 1;
    mcyc = mcyc + 1;
    if (rst) begin
      mq.delete();
      m_a = 0; m_b = 0; m_res = 0; m_dzcnt = 0;
      m_rv = 0; m_busy = 0; m_dzerr = 0; m_live = 1;
    end else if (m_live) begin
      did_push = in_valid && (mq.size() < DEPTH);
      m_dzerr = 0;
      if (m_rv) begin
        if (res_ready) begin m_rv = 0; m_busy = 0; end
      end else if (m_busy) begin
        if (mcyc == m_cap_at) begin m_res = ctx(m_a, m_b); m_rv = 1; end
      end else if (mq.size() > 0) begin
        p = mq.pop_front();
        if (p.pb == 0) begin
          m_dzerr = 1;
          if (m_dzcnt != 8'hFF) m_dzcnt = m_dzcnt + 8'd1;
        end else begin
          m_a = p.pa; m_b = p.pb; m_busy = 1; m_cap_at = mcyc + HOLD;
        end
      end
      if (did_push) mq.push_back({in_a, in_b});
    end
  end

  // Per-cycle comparison of every output against the model, plus event counters.
  int dz_pulses = 0;
  int rv_cycles = 0;
  initial forever begin
    @(negedge clk);
    if (dz_err === 1'b1) dz_pulses = dz_pulses + 1;
    if (res_valid === 1'b1) rv_cycles = rv_cycles + 1;
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
      chk("a", 32'(a), 32'(m_a));
      chk("b", 32'(b), 32'(m_b));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("res", 32'(res), 32'(m_res));
      chk("dz_err", 32'(dz_err), 32'(m_dzerr));
      chk("dz_cnt", 32'(dz_cnt), 32'(m_dzcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] pa, input logic [7:0] pb);
    bit acc;
    int n;
    n = 0;
    in_a = pa;
    in_b = pb;
    in_valid = 1'b1;
    do begin
      acc = (in_ready === 1'b1);
      tick();
      n = n + 1;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) timeout("push");
  endtask

  task automatic wait_valid(output int t, output logic [7:0] r);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      tick();
      n = n + 1;
    end
    if (res_valid !== 1'b1) timeout("wait_valid");
    t = cyc;
    r = res;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2;
    logic [7:0] r1, r2;
    pair_t tbl[6];

    // Reset values
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_dz_cnt", 32'(dz_cnt), 0);

    // Single pair latency
    res_ready = 1'b1;
    push(8'd10, 8'd3);
    tick();
    chk("t1_a", 32'(a), 10);
    chk("t1_b", 32'(b), 3);
    repeat (3) tick();
    chk("t1_rv_early", 32'(res_valid), 0);
    tick();
    chk("t1_rv", 32'(res_valid), 1);
    chk("t1_res", 32'(res), 37);
    tick();
    chk("t1_rv_pulse", 32'(res_valid), 0);

    // Back-to-back pairs and throughput
    push(8'd200, 8'd100);
    push(8'd7, 8'd2);
    wait_valid(t1, r1);
    tick();
    wait_valid(t2, r2);
    chk("t2_res1", 32'(r1), 132);
    chk("t2_res2", 32'(r2), 19);
    chk("t2_spacing", 32'(t2 - t1), 6);
    tick();

    // Zero divisor drop
    do_reset();
    dz_pulses = 0;
    push(8'd5, 8'd0);
    push(8'd9, 8'd4);
    wait_valid(t1, r1);
    chk("t3_res", 32'(r1), 41);
    tick();
    chk("t3_dz_cnt", 32'(dz_cnt), 1);
    chk("t3_dz_pulses", 32'(dz_pulses), 1);

    // Backpressure: result stalled, FIFO fills, extra pair waits
    do_reset();
    res_ready = 1'b0;
    tbl[0] = {8'd11, 8'd2}; tbl[1] = {8'd40, 8'd7}; tbl[2] = {8'd3, 8'd9};
    tbl[3] = {8'd250, 8'd1}; tbl[4] = {8'd17, 8'd17}; tbl[5] = {8'd99, 8'd5};
    for (int i = 0; i < 5; i++) push(tbl[i].pa, tbl[i].pb);
    in_a = tbl[5].pa;
    in_b = tbl[5].pb;
    in_valid = 1'b1;
    repeat (6) tick();
    chk("t4_count", 32'(count), 4);
    chk("t4_in_ready", 32'(in_ready), 0);
    chk("t4_rv", 32'(res_valid), 1);
    chk("t4_res_held", 32'(res), 32'(ctx(tbl[0].pa, tbl[0].pb)));
    repeat (3) tick();
    chk("t4_res_stable", 32'(res), 32'(ctx(tbl[0].pa, tbl[0].pb)));
    res_ready = 1'b1;
    fork
      push(tbl[5].pa, tbl[5].pb);
      begin
        for (int i = 0; i < 6; i++) begin
          wait_valid(t1, r1);
          chk("t4_order", 32'(r1), 32'(ctx(tbl[i].pa, tbl[i].pb)));
          tick();
        end
      end
    join

    // Drop counter saturation
    do_reset();
    rv_cycles = 0;
    for (int i = 0; i < 260; i++) push(8'(i), 8'd0);
    repeat (3) tick();
    chk("t5_dz_sat", 32'(dz_cnt), 255);
    chk("t5_no_result", 32'(rv_cycles), 0);

    // Reset during HOLD with pairs queued
    do_reset();
    push(8'd1, 8'd1);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    push(8'd4, 8'd4);
    chk("t6_count_pre", 32'(count), 3);
    rst = 1'b1;
    tick();
    chk("t6_count", 32'(count), 0);
    chk("t6_rv", 32'(res_valid), 0);
    chk("t6_a", 32'(a), 0);
    chk("t6_b", 32'(b), 0);
    rst = 1'b0;
    rv_cycles = 0;
    repeat (20) tick();
    chk("t6_no_stale", 32'(rv_cycles), 0);

    // Randomized traffic against the model
    do_reset();
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    repeat (60) tick();
    chk("rand_drained", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
